// File: rtl/demux_conductual_pkg.sv
// Shared definitions for the 1:2 demultiplexer: lane-state encodings and default widths.
package demux_conductual_pkg;

  localparam logic LANE_EMPTY = 1'b0;
  localparam logic LANE_FULL  = 1'b1;

  localparam int unsigned DEFAULT_WIDTH     = 2;
  localparam int unsigned DEFAULT_CNT_WIDTH = 6;

endpackage

// File: rtl/demux_conductual_lane.sv
// One output lane: single-entry register slice with a FULL/EMPTY bit and a delivered-word counter.
module demux_conductual_lane
  import demux_conductual_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fill,
  input  logic [WIDTH-1:0]     data,
  input  logic                 ready_out,
  output logic [WIDTH-1:0]     data_out,
  output logic                 valid_out,
  output logic                 can_accept,
  output logic [CNT_WIDTH-1:0] contador
);

  logic                 state_q, state_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 drain;

  assign drain = (state_q == LANE_FULL) && ready_out;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    // Fill wins over drain so a simultaneous drain+fill reloads without a bubble.
    if (fill) begin
      state_d = LANE_FULL;
      data_d  = data;
    end else if (drain) begin
      state_d = LANE_EMPTY;
    end
    if (drain) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LANE_EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_out   = data_q;
  assign valid_out  = (state_q == LANE_FULL);
  assign can_accept = (state_q == LANE_EMPTY) || ready_out;
  assign contador   = cnt_q;

endmodule

// File: rtl/demux_conductual.sv
// 1:2 demultiplexer: steers each accepted input word to the lane picked by selector.
module demux_conductual
  import demux_conductual_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 selector,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  logic [WIDTH-1:0]     data_in,
  output logic [WIDTH-1:0]     data_out0,
  output logic                 valid_out0,
  input  logic                 ready_out0,
  output logic [WIDTH-1:0]     data_out1,
  output logic                 valid_out1,
  input  logic                 ready_out1,
  output logic [CNT_WIDTH-1:0] contador_0,
  output logic [CNT_WIDTH-1:0] contador_1
);

  logic can_accept0, can_accept1;
  logic accept, fill0, fill1;

  // Only the selected lane gates the input; a stalled other lane never blocks.
  assign ready_in = !reset && (selector ? can_accept1 : can_accept0);
  assign accept   = valid_in && ready_in;
  assign fill0    = accept && !selector;
  assign fill1    = accept && selector;

  demux_conductual_lane #(
    .WIDTH    (WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_lane0 (
    .clk       (clk),
    .reset     (reset),
    .fill      (fill0),
    .data      (data_in),
    .ready_out (ready_out0),
    .data_out  (data_out0),
    .valid_out (valid_out0),
    .can_accept(can_accept0),
    .contador  (contador_0)
  );

  demux_conductual_lane #(
    .WIDTH    (WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_lane1 (
    .clk       (clk),
    .reset     (reset),
    .fill      (fill1),
    .data      (data_in),
    .ready_out (ready_out1),
    .data_out  (data_out1),
    .valid_out (valid_out1),
    .can_accept(can_accept1),
    .contador  (contador_1)
  );

endmodule

// File: tb/tb_demux_conductual.sv
// Bench for demux_conductual: directed stimulus plus a per-lane queue scoreboard checked every cycle.
module tb_demux_conductual;

  logic       clk;
  logic       reset;
  logic       selector;
  logic       valid_in;
  logic       ready_in;
  logic [1:0] data_in;
  logic [1:0] data_out0, data_out1;
  logic       valid_out0, valid_out1;
  logic       ready_out0, ready_out1;
  logic [5:0] contador_0, contador_1;

  int n_checks = 0;
  int n_fail   = 0;

  demux_conductual dut (
    .clk       (clk),
    .reset     (reset),
    .selector  (selector),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .data_out0 (data_out0),
    .valid_out0(valid_out0),
    .ready_out0(ready_out0),
    .data_out1 (data_out1),
    .valid_out1(valid_out1),
    .ready_out1(ready_out1),
    .contador_0(contador_0),
    .contador_1(contador_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: queues hold words accepted but not yet drained, so occupancy is the lane state.
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] exp_dout0 = 2'b00, exp_dout1 = 2'b00;
  logic [5:0] exp_cnt0 = 6'd0, exp_cnt1 = 6'd0;
  logic       exp_ready;
  logic       full0, full1;

  always @(negedge clk) begin
    full0 = (q0.size() != 0);
    full1 = (q1.size() != 0);
    exp_ready = !reset && (selector ? (!full1 || ready_out1) : (!full0 || ready_out0));

    check("valid_out0", {31'd0, valid_out0}, {31'd0, full0});
    check("valid_out1", {31'd0, valid_out1}, {31'd0, full1});
    check("data_out0", {30'd0, data_out0}, {30'd0, full0 ? q0[0] : exp_dout0});
    check("data_out1", {30'd0, data_out1}, {30'd0, full1 ? q1[0] : exp_dout1});
    check("contador_0", {26'd0, contador_0}, {26'd0, exp_cnt0});
    check("contador_1", {26'd0, contador_1}, {26'd0, exp_cnt1});
    check("ready_in", {31'd0, ready_in}, {31'd0, exp_ready});

    // Advance the model to the state after the coming rising edge.
    if (reset) begin
      q0.delete();
      q1.delete();
      exp_dout0 = 2'b00;
      exp_dout1 = 2'b00;
      exp_cnt0  = 6'd0;
      exp_cnt1  = 6'd0;
    end else begin
      if (full0 && ready_out0) begin
        void'(q0.pop_front());
        exp_cnt0 = exp_cnt0 + 6'd1;
      end
      if (full1 && ready_out1) begin
        void'(q1.pop_front());
        exp_cnt1 = exp_cnt1 + 6'd1;
      end
      if (valid_in && exp_ready) begin
        if (selector) begin
          q1.push_back(data_in);
          exp_dout1 = data_in;
        end else begin
          q0.push_back(data_in);
          exp_dout0 = data_in;
        end
      end
    end
  end

  task automatic send(input logic sel, input logic [1:0] d);
    int waited = 0;
    selector = sel;
    data_in  = d;
    valid_in = 1'b1;
    @(negedge clk);
    while (!ready_in && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!ready_in) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: ready_in stuck at 0, required 1 (t=%0t)", $time);
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    selector   = 1'b0;
    valid_in   = 1'b1;
    data_in    = 2'b11;
    ready_out0 = 1'b0;
    ready_out1 = 1'b0;

    // 1: reset held two cycles with valid_in asserted.
    idle(2);
    check("rst_ready_in", {31'd0, ready_in}, 32'd0);
    check("rst_valid", {30'd0, valid_out1, valid_out0}, 32'd0);
    check("rst_cnt", {20'd0, contador_1, contador_0}, 32'd0);
    check("rst_data", {28'd0, data_out1, data_out0}, 32'd0);
    valid_in = 1'b0;
    reset    = 1'b0;
    idle(1);

    // 2: three back-to-back lane-0 words with the consumer always ready.
    ready_out0 = 1'b1;
    send(1'b0, 2'b01);
    check("t2_d01", {30'd0, data_out0}, 32'd1);
    send(1'b0, 2'b10);
    check("t2_d10", {30'd0, data_out0}, 32'd2);
    send(1'b0, 2'b11);
    check("t2_d11", {30'd0, data_out0}, 32'd3);
    idle(2);
    check("t2_cnt0", {26'd0, contador_0}, 32'd3);
    check("t2_valid1", {31'd0, valid_out1}, 32'd0);
    check("t2_hold0", {30'd0, data_out0}, 32'd3);

    // 3: stalled lane 1 blocks only lane-1 words.
    send(1'b1, 2'b10);
    selector = 1'b1;
    data_in  = 2'b11;
    valid_in = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("t3_blocked", {31'd0, ready_in}, 32'd0);
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    send(1'b0, 2'b01);
    idle(2);
    check("t3_cnt0", {26'd0, contador_0}, 32'd4);
    check("t3_d0", {30'd0, data_out0}, 32'd1);
    check("t3_hold1", {30'd0, data_out1}, 32'd2);
    check("t3_valid1", {31'd0, valid_out1}, 32'd1);
    ready_out1 = 1'b1;
    idle(2);
    check("t3_cnt1", {26'd0, contador_1}, 32'd1);
    check("t3_drained1", {31'd0, valid_out1}, 32'd0);

    // 4: drain and refill lane 0 in the same cycle.
    ready_out0 = 1'b0;
    send(1'b0, 2'b01);
    ready_out0 = 1'b1;
    send(1'b0, 2'b11);
    check("t4_valid0", {31'd0, valid_out0}, 32'd1);
    check("t4_d11", {30'd0, data_out0}, 32'd3);
    check("t4_cnt0", {26'd0, contador_0}, 32'd5);
    idle(2);
    check("t4_cnt0_final", {26'd0, contador_0}, 32'd6);

    // 5: lane-1 counter wrap after 64 deliveries from a clean start.
    pulse_reset();
    for (int i = 0; i < 63; i++) send(1'b1, 2'(i));
    idle(2);
    check("t5_cnt63", {26'd0, contador_1}, 32'd63);
    send(1'b1, 2'b10);
    idle(2);
    check("t5_wrap", {26'd0, contador_1}, 32'd0);

    // 6: reset while both lanes are full and stalled.
    ready_out0 = 1'b0;
    ready_out1 = 1'b0;
    send(1'b0, 2'b10);
    send(1'b1, 2'b01);
    check("t6_full", {30'd0, valid_out1, valid_out0}, 32'd3);
    selector = 1'b0;
    data_in  = 2'b11;
    valid_in = 1'b1;
    ready_out0 = 1'b1;
    pulse_reset();
    valid_in = 1'b0;
    ready_out0 = 1'b0;
    check("t6_rst_valid", {30'd0, valid_out1, valid_out0}, 32'd0);
    check("t6_rst_cnt", {20'd0, contador_1, contador_0}, 32'd0);
    ready_out0 = 1'b1;
    send(1'b0, 2'b10);
    check("t6_post_d", {30'd0, data_out0}, 32'd2);
    idle(2);
    check("t6_post_cnt", {26'd0, contador_0}, 32'd1);
    check("t6_q_empty", q0.size() + q1.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
